// File: rtl/rd_fifo_arbiter.sv
// Read-side scheduler for a crossbar output port fed by NUM_SRC FIFOs.
// Round-robin selection with burst locking, one pop per cycle, and a
// single-entry registered output stage toward the downstream consumer.
//
// Handshake: out_valid_o=1 means out_data_o/out_src_o/out_last_o hold a word;
// the word is consumed at a posedge where out_valid_o && out_ready_i. The
// stage may reload in that same cycle, so back-to-back words flow at one per
// cycle while out_ready_i stays high.
module rd_fifo_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          rclk,
    input  logic                          rrst,
    input  logic [NUM_SRC-1:0]            src_empty_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rdata_i,
    output logic [NUM_SRC-1:0]            src_rpop_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [$clog2(NUM_SRC)-1:0]    out_src_o,
    output logic                          out_last_o,
    output logic                          dbg_state_o,
    output logic [3:0]                    dbg_burst_cnt_o,
    output logic [$clog2(NUM_SRC)-1:0]    dbg_rr_ptr_o
);
    localparam int SW = $clog2(NUM_SRC);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           cur_q, cur_d;
    logic [3:0]              burst_cnt_q, burst_cnt_d;
    logic [SW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [SW-1:0]           out_src_q;
    logic                    out_last_q;

    logic                    slot_free;
    logic                    found;
    logic [SW-1:0]           pick;
    logic                    load;
    logic [SW-1:0]           grant;
    logic                    grant_end;
    logic [3:0]              cnt_next;

    // Index following v, wrapping at NUM_SRC (which need not be a power of 2).
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
        return (v == SW'(NUM_SRC - 1)) ? '0 : v + SW'(1);
    endfunction

    // Round-robin scan: first non-empty FIFO starting at rr_ptr_q.
    always_comb begin
        logic [SW:0] idx;
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        // Walk offsets high to low so the smallest offset is the final winner.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + (SW+1)'(k);
            if (idx >= (SW+1)'(NUM_SRC)) begin
                idx = idx - (SW+1)'(NUM_SRC);
            end
            if (!src_empty_i[idx[SW-1:0]]) begin
                found = 1'b1;
                pick  = idx[SW-1:0];
            end
        end
    end

    // Next-state, pop decision and grant bookkeeping.
    always_comb begin
        slot_free   = ~out_valid_q | out_ready_i;
        state_d     = state_q;
        cur_d       = cur_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        load        = 1'b0;
        grant       = cur_q;
        grant_end   = 1'b0;
        cnt_next    = burst_cnt_q + 4'd1;
        src_rpop_o  = '0;

        case (state_q)
            IDLE: begin
                cnt_next = 4'd1;
                if (found && slot_free) begin
                    load  = 1'b1;
                    grant = pick;
                    cur_d = pick;
                    if (cnt_next == 4'(MAX_BURST)) begin
                        grant_end   = 1'b1;
                        rr_ptr_d    = wrap_inc(pick);
                        burst_cnt_d = 4'd0;
                    end else begin
                        burst_cnt_d = cnt_next;
                        state_d     = BURST;
                    end
                end
            end
            BURST: begin
                // A stall freezes the grant even if the source runs dry meanwhile.
                if (slot_free) begin
                    if (src_empty_i[cur_q]) begin
                        rr_ptr_d    = wrap_inc(cur_q);
                        burst_cnt_d = 4'd0;
                        state_d     = IDLE;
                    end else begin
                        load  = 1'b1;
                        grant = cur_q;
                        if (cnt_next == 4'(MAX_BURST)) begin
                            grant_end   = 1'b1;
                            rr_ptr_d    = wrap_inc(cur_q);
                            burst_cnt_d = 4'd0;
                            state_d     = IDLE;
                        end else begin
                            burst_cnt_d = cnt_next;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // No pop may escape while reset is asserted.
        if (rrst) begin
            load = 1'b0;
        end
        if (load) begin
            src_rpop_o[grant] = 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            burst_cnt_q <= 4'd0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Single-entry output stage: load on pop, drain on accept, else hold.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= src_rdata_i[grant*DATA_WIDTH +: DATA_WIDTH];
            out_src_q   <= grant;
            out_last_q  <= grant_end;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o     = out_valid_q;
    assign out_data_o      = out_data_q;
    assign out_src_o       = out_src_q;
    assign out_last_o      = out_last_q;
    assign dbg_state_o     = (state_q == BURST);
    assign dbg_burst_cnt_o = burst_cnt_q;
    assign dbg_rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_rd_fifo_arbiter.sv
// Bench for rd_fifo_arbiter: ring-buffer FIFO models, a grant-level reference
// model run once per cycle, and a scoreboard of expected output words.
module tb_rd_fifo_arbiter;
    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int MB   = 4;
    localparam int SW   = 2;
    localparam int RING = 256;

    logic             rclk = 1'b0;
    logic             rrst;
    logic [NS-1:0]    src_empty;
    logic [NS*DW-1:0] src_rdata;
    logic [NS-1:0]    src_rpop;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [SW-1:0]    out_src;
    logic             out_last;
    logic             dbg_state;
    logic [3:0]       dbg_cnt;
    logic [SW-1:0]    dbg_rr;

    int total = 0;
    int bad   = 0;

    // FIFO contents: main process writes mem/wp, pop process advances rp.
    logic [DW-1:0] mem [NS][RING];
    int            wp [NS];
    int            rp [NS];
    logic [NS-1:0] pend_mask = '0;

    // Scoreboard entries are {last, src, data}.
    logic [DW+SW:0] exp_q[$];

    // Reference model: which source owns the grant, pops taken, scan start.
    int owner      = -1;
    int taken      = 0;
    int next_start = 0;
    bit m_full     = 1'b0;
    int lasts_seen = 0;

    always #5 rclk = ~rclk;

    rd_fifo_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .rclk            (rclk),
        .rrst            (rrst),
        .src_empty_i     (src_empty),
        .src_rdata_i     (src_rdata),
        .src_rpop_o      (src_rpop),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_data_o      (out_data),
        .out_src_o       (out_src),
        .out_last_o      (out_last),
        .dbg_state_o     (dbg_state),
        .dbg_burst_cnt_o (dbg_cnt),
        .dbg_rr_ptr_o    (dbg_rr)
    );

    for (genvar g = 0; g < NS; g++) begin : g_fifo
        assign src_empty[g]          = (wp[g] == rp[g]);
        assign src_rdata[g*DW +: DW] = mem[g][rp[g][7:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit f_empty(input int s);
        return wp[s] == rp[s];
    endfunction

    task automatic push_word(input int s);
        mem[s][wp[s][7:0]] = $urandom;
        wp[s]++;
    endtask

    // Clock/reset pacing: return 2 time units after a rising edge.
    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    // Bounded wait for the next cycle that issues a pop.
    task automatic wait_pop(output logic [NS-1:0] m);
        m = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            if (src_rpop != '0) begin
                m = src_rpop;
                break;
            end
        end
    endtask

    // FIFOs advance on the edge that follows a model-predicted pop.
    always @(posedge rclk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (pend_mask[i]) rp[i]++;
        end
        pend_mask = '0;
    end

    // Monitor + reference model, evaluated mid-cycle on stable inputs.
    always @(negedge rclk) begin
        logic [NS-1:0]  exp_mask;
        logic [DW+SW:0] e;
        int             sel;
        bit             last;
        bit             free;
        if (rrst) begin
            check("rpop_during_reset", src_rpop, '0);
            owner = -1; taken = 0; next_start = 0; m_full = 1'b0;
            exp_q.delete();
            pend_mask = '0;
        end else begin
            check("out_valid", out_valid, m_full);
            check("busy_state", dbg_state, owner >= 0);
            check("burst_cnt", dbg_cnt, taken);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[DW-1:0]);
                    check("out_src", out_src, e[DW+SW-1:DW]);
                    check("out_last", out_last, e[DW+SW]);
                    if (e[DW+SW]) lasts_seen++;
                end
            end
            exp_mask = '0;
            sel  = -1;
            last = 1'b0;
            free = !m_full || out_ready;
            if (free) begin
                if (owner >= 0) begin
                    if (f_empty(owner)) begin
                        next_start = (owner + 1) % NS;
                        owner = -1;
                        taken = 0;
                    end else begin
                        sel = owner;
                    end
                end else begin
                    for (int k = 0; k < NS; k++) begin
                        if (sel < 0 && !f_empty((next_start + k) % NS)) sel = (next_start + k) % NS;
                    end
                    if (sel >= 0) begin
                        owner = sel;
                        taken = 0;
                    end
                end
                if (sel >= 0) begin
                    taken++;
                    if (taken == MB) begin
                        last = 1'b1;
                        next_start = (sel + 1) % NS;
                        owner = -1;
                        taken = 0;
                    end
                    exp_mask[sel] = 1'b1;
                    exp_q.push_back({last, SW'(sel), mem[sel][rp[sel][7:0]]});
                end
            end
            if (sel >= 0) m_full = 1'b1;
            else if (out_ready) m_full = 1'b0;
            check("src_rpop", src_rpop, exp_mask);
            pend_mask = exp_mask;
        end
    end

    initial begin
        logic [NS-1:0] m;
        logic [DW-1:0] w2;
        for (int i = 0; i < NS; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        rrst = 1'b1;
        out_ready = 1'b1;

        // Reset held 3 cycles with every FIFO non-empty.
        for (int i = 0; i < NS; i++) repeat (3) push_word(i);
        repeat (3) tick();
        rrst = 1'b0;
        wait_pop(m);
        check("first_pop_after_reset", m, 4'b0001);
        repeat (30) tick();

        // Burst limit: two sources with 10 words each.
        lasts_seen = 0;
        repeat (10) push_word(0);
        repeat (10) push_word(1);
        repeat (40) tick();
        check("burst_last_count", lasts_seen, 4);
        check("burst_src0_drained", rp[0], wp[0]);
        check("burst_src1_drained", rp[1], wp[1]);

        // Drain: src2 holds only two words.
        repeat (2) push_word(2);
        repeat (10) tick();
        check("drain_rr_ptr", dbg_rr, 3);
        check("drain_idle_valid", out_valid, 0);

        // Wrap/fairness: src3 and src0 only, scan starts at src3.
        repeat (6) push_word(3);
        repeat (6) push_word(0);
        wait_pop(m);
        check("wrap_first_grant", m, 4'b1000);
        repeat (30) tick();
        check("wrap_src3_pops", rp[3], wp[3]);
        check("wrap_src0_pops", rp[0], wp[0]);

        // Back-pressure for 5 cycles after the second word of a burst.
        w2 = '0;
        for (int k = 0; k < 8; k++) begin
            push_word(1);
            if (k == 1) w2 = mem[1][8'(wp[1] - 1)];
        end
        tick();
        tick();
        out_ready = 1'b0;
        repeat (5) tick();
        check("bp_data_stable", out_data, w2);
        check("bp_cnt_held", dbg_cnt, 2);
        check("bp_no_pop", src_rpop, '0);
        out_ready = 1'b1;
        repeat (20) tick();
        check("bp_src1_drained", rp[1], wp[1]);

        // Reset in the middle of a src1 burst.
        repeat (6) push_word(1);
        tick();
        tick();
        rrst = 1'b1;
        repeat (3) push_word(0);
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_out_last", out_last, 0);
        check("rst_state", dbg_state, 0);
        check("rst_cnt", dbg_cnt, 0);
        check("rst_rr_ptr", dbg_rr, 0);
        rrst = 1'b0;
        wait_pop(m);
        check("rst_restart_src0", m, 4'b0001);
        repeat (30) tick();

        // Randomized traffic, back-pressure and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rrst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NS; i++) begin
                if (wp[i] - rp[i] < 20 && $urandom_range(0, 5) == 0) push_word(i);
            end
            tick();
        end
        rrst = 1'b0;
        out_ready = 1'b1;
        repeat (80) tick();
        check("final_scoreboard_empty", exp_q.size(), 0);
        for (int i = 0; i < NS; i++) check("final_fifo_drained", wp[i] - rp[i], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
